// File: rtl/captcha_round_sequencer.sv
// Round controller for the circle-click CAPTCHA: sequences LOAD/PLAY/GAP rounds, latches a
// per-round random modifier and turns pass/fail/timeout/abort results into a session verdict.
module captcha_round_sequencer #(
  parameter int unsigned ROUNDS      = 3,
  parameter int unsigned MAX_FAILS   = 2,
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned GAP_CYC     = 1_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] rand_in,
  input  logic        pass_in,
  input  logic        fail_in,
  input  logic        back_in,
  output logic        circle_en,
  output logic [12:0] rand_mod,
  output logic [3:0]  round_idx,
  output logic [3:0]  fail_cnt,
  output logic        busy,
  output logic        verified,
  output logic        locked_out,
  output logic        aborted
);

  localparam int unsigned ToW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [ToW-1:0]  ToLast    = ToW'(TIMEOUT_CYC - 1);
  localparam logic [GapW-1:0] GapLast   = GapW'(GAP_CYC - 1);
  localparam logic [3:0]      RoundsLim = 4'(ROUNDS);
  localparam logic [3:0]      FailsLim  = 4'(MAX_FAILS);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPlay,
    StGap,
    StDoneOk,
    StDoneLock
  } state_e;

  state_e          state_q, state_d;
  logic [12:0]     rand_mod_q, rand_mod_d;
  logic [3:0]      round_q, round_d;
  logic [3:0]      fails_q, fails_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic            aborted_q, aborted_d;
  logic [3:0]      round_inc, fails_inc;

  // Saturating increments keep the 4-bit counters from wrapping on out-of-range parameters.
  assign round_inc = (round_q == 4'd15) ? 4'd15 : round_q + 4'd1;
  assign fails_inc = (fails_q == 4'd15) ? 4'd15 : fails_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    rand_mod_d = rand_mod_q;
    round_d    = round_q;
    fails_d    = fails_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    aborted_d  = 1'b0;

    unique case (state_q)
      StIdle, StDoneOk, StDoneLock: begin
        if (start) begin
          round_d = 4'd0;
          fails_d = 4'd0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Force a different modifier when the random source repeats itself.
        rand_mod_d = (rand_in == rand_mod_q) ? (rand_in ^ 13'h0001) : rand_in;
        to_cnt_d   = '0;
        state_d    = StPlay;
      end
      StPlay: begin
        to_cnt_d = to_cnt_q + ToW'(1);
        if (back_in) begin
          aborted_d = 1'b1;
          state_d   = StIdle;
        end else if (fail_in || (to_cnt_q == ToLast)) begin
          fails_d   = fails_inc;
          gap_cnt_d = '0;
          state_d   = (fails_inc == FailsLim) ? StDoneLock : StGap;
        end else if (pass_in) begin
          round_d   = round_inc;
          gap_cnt_d = '0;
          state_d   = (round_inc == RoundsLim) ? StDoneOk : StGap;
        end
      end
      StGap: begin
        if (back_in) begin
          aborted_d = 1'b1;
          state_d   = StIdle;
        end else if (gap_cnt_q == GapLast) begin
          state_d = StLoad;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      rand_mod_q <= '0;
      round_q    <= '0;
      fails_q    <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rand_mod_q <= rand_mod_d;
      round_q    <= round_d;
      fails_q    <= fails_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      aborted_q  <= aborted_d;
    end
  end

  assign circle_en  = (state_q == StPlay);
  assign rand_mod   = rand_mod_q;
  assign round_idx  = round_q;
  assign fail_cnt   = fails_q;
  assign busy       = !((state_q == StIdle) || (state_q == StDoneOk) || (state_q == StDoneLock));
  assign verified   = (state_q == StDoneOk);
  assign locked_out = (state_q == StDoneLock);
  assign aborted    = aborted_q;

endmodule
